rom_rd_arbiter: RTL and testbench

Shares one synchronous single-port ROM read port between N_PORTS independent requesters. Each requester presents addresses on its own DTI-style address channel and receives read data on its own DTI-style data channel. The block arbitrates round-robin, drives the ROM enable and address, and tracks which requester owns the single outstanding read. It sits between the cascade-classifier feature/stage fetch units and a shared coefficient ROM, in place of a per-requester read port.

---
 rtl/rom_rd_arbiter.sv | 81 ++++++++
 tb/tb_rom_rd_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_arbiter.sv
// rom_rd_arbiter: round-robin sharing of one synchronous ROM read port between N_PORTS requesters
// Each requester has its own address/data channel. At most one read is in flight at a time, and
// a new read is issued only when the previous response is absent or is being consumed.
module rom_rd_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_DATA  = 16,
    parameter int W_ADDR  = 16,
    parameter int W_ID    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS*W_ADDR-1:0] addr_data,
    input  logic [N_PORTS-1:0]        addr_valid,
    output logic [N_PORTS-1:0]        addr_ready,
    output logic [W_DATA-1:0]         data_data,
    output logic [N_PORTS-1:0]        data_valid,
    input  logic [N_PORTS-1:0]        data_ready,
    output logic                      rom_en_o,
    output logic [W_ADDR-1:0]         rom_addr_o,
    input  logic [W_DATA-1:0]         rom_data_i
);
    logic              r_resp_valid;
    logic [W_ID-1:0]   r_owner;
    logic [W_ID-1:0]   r_rr_ptr;
    logic [W_ADDR-1:0] w_addr_arr [N_PORTS];
    logic [W_ID-1:0]   w_idx;
    logic [W_ID-1:0]   w_gnt;
    logic [W_ID-1:0]   w_nxt;
    logic              w_gnt_vld;
    logic              w_slot_free;

    for (genvar k = 0; k < N_PORTS; k++) begin : g_addr
        assign w_addr_arr[k] = addr_data[k*W_ADDR +: W_ADDR];
    end

    // The reset term keeps every handshake output low while reset is held, even with requests present.
    assign w_slot_free = rst && (!r_resp_valid || data_ready[r_owner]);
    assign rom_en_o    = w_slot_free && w_gnt_vld;
    assign rom_addr_o  = w_gnt_vld ? w_addr_arr[w_gnt] : '0;
    assign data_data   = rom_data_i;
    assign w_nxt       = (w_gnt == W_ID'(N_PORTS - 1)) ? '0 : w_gnt + 1'b1;

    // Round-robin search from r_rr_ptr; scanning downward lets the nearest valid port win.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            w_idx = W_ID'((int'(r_rr_ptr) + i) % N_PORTS);
            if (rst && addr_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    // Decode the grant into per-port ready, and the owner into per-port data valid.
    always_comb begin
        addr_ready = '0;
        data_valid = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            addr_ready[k] = rom_en_o && (w_gnt == W_ID'(k));
            data_valid[k] = r_resp_valid && (r_owner == W_ID'(k));
        end
    end

    // Track the single outstanding read. The pointer moves only on an issued read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
        end else if (w_slot_free) begin
            r_resp_valid <= rom_en_o;
            if (rom_en_o) begin
                r_owner  <= w_gnt;
                r_rr_ptr <= w_nxt;
            end
        end
    end
endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb_rom_rd_arbiter: directed and randomized checks of rom_rd_arbiter against a behavioural model
// Two instances are built, with 2 ports and with 4 ports. Each instance has a registered ROM
// model, and a reference model is evaluated on every falling clock edge.
module tb_rom_rd_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  av2 = '0, dr2 = '0, ar2, dv2, hs2 = '0;
    logic [31:0] ad2 = '0;
    logic        en2;
    logic [15:0] addr2, data2, rom_q2 = '0;
    logic [3:0]  av4 = '0, dr4 = '0, ar4, dv4, hs4 = '0;
    logic [63:0] ad4 = '0;
    logic        en4;
    logic [15:0] addr4, data4, rom_q4 = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        m_rv [2]  = '{1'b0, 1'b0};
    int          m_own [2] = '{0, 0};
    int          m_ptr [2] = '{0, 0};
    logic [15:0] m_dat [2] = '{16'h0, 16'h0};

    always #5 clk = ~clk;

    rom_rd_arbiter #(.N_PORTS(2)) u_dut2 (
        .clk(clk), .rst(rst), .addr_data(ad2), .addr_valid(av2), .addr_ready(ar2),
        .data_data(data2), .data_valid(dv2), .data_ready(dr2),
        .rom_en_o(en2), .rom_addr_o(addr2), .rom_data_i(rom_q2)
    );

    rom_rd_arbiter #(.N_PORTS(4)) u_dut4 (
        .clk(clk), .rst(rst), .addr_data(ad4), .addr_valid(av4), .addr_ready(ar4),
        .data_data(data4), .data_valid(dv4), .data_ready(dr4),
        .rom_en_o(en4), .rom_addr_o(addr4), .rom_data_i(rom_q4)
    );

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5a5a;
    endfunction

    // Synchronous ROMs whose outputs hold while they are not enabled.
    always @(posedge clk) begin
        if (en2) rom_q2 <= rom_f(addr2);
        if (en4) rom_q4 <= rom_f(addr4);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the first valid port at or after the pointer wins. Outputs are compared, then the model advances to the state after the coming edge.
    task automatic model_check(input int u, input int n, input logic r, input logic [3:0] av,
                               input logic [3:0] dr, input logic [63:0] ad, input logic [3:0] o_ar,
                               input logic [3:0] o_dv, input logic o_en, input logic [15:0] o_addr,
                               input logic [15:0] o_data);
        int          g = 0;
        logic        gv = 1'b0;
        logic        slot;
        logic [3:0]  e_ar, e_dv;
        logic [15:0] e_addr;
        for (int k = 0; k < n; k++) begin
            if (!gv && r && av[2'((m_ptr[u] + k) % n)]) begin
                gv = 1'b1;
                g  = (m_ptr[u] + k) % n;
            end
        end
        slot   = r && (!m_rv[u] || dr[2'(m_own[u])]);
        e_ar   = (slot && gv) ? 4'(1 << g) : 4'h0;
        e_dv   = m_rv[u] ? 4'(1 << m_own[u]) : 4'h0;
        e_addr = gv ? ad[g*16 +: 16] : 16'h0;
        chk($sformatf("n%0d_addr_ready", n), {28'h0, o_ar}, {28'h0, e_ar});
        chk($sformatf("n%0d_data_valid", n), {28'h0, o_dv}, {28'h0, e_dv});
        chk($sformatf("n%0d_rom_en", n), {31'h0, o_en}, {31'h0, slot && gv});
        chk($sformatf("n%0d_rom_addr", n), {16'h0, o_addr}, {16'h0, e_addr});
        if (m_rv[u]) chk($sformatf("n%0d_data", n), {16'h0, o_data}, {16'h0, m_dat[u]});
        if (slot) begin
            m_rv[u] = gv;
            if (gv) begin
                m_own[u] = g;
                m_ptr[u] = (g + 1) % n;
                m_dat[u] = rom_f(e_addr);
            end
        end
    endtask

    always @(negedge clk) begin
        model_check(0, 2, rst, {2'b0, av2}, {2'b0, dr2}, {32'h0, ad2}, {2'b0, ar2}, {2'b0, dv2}, en2, addr2, data2);
        model_check(1, 4, rst, av4, dr4, ad4, ar4, dv4, en4, addr4, data4);
        hs2 <= ar2 & av2;
        hs4 <= ar4 & av4;
    end

    always @(negedge rst) begin
        m_rv  = '{1'b0, 1'b0};
        m_own = '{0, 0};
        m_ptr = '{0, 0};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        av2 = '0;
        av4 = '0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        av2 = 2'b11;
        ad2 = {16'h7, 16'h9};
        repeat (2) step();
        @(negedge clk);
        chk("rst_data_valid", {30'h0, dv2}, 32'h0);
        chk("rst_addr_ready", {30'h0, ar2}, 32'h0);
        chk("rst_rom_en", {31'h0, en2}, 32'h0);
        chk("rst_rom_addr", {16'h0, addr2}, 32'h0);
        step();
        rst = 1'b1;
        av2 = 2'b01;
        dr2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            ad2[15:0] = 16'(i);
            @(negedge clk);
            chk("seq_rom_en", {31'h0, en2}, 32'h1);
            chk("seq_ready1", {31'h0, ar2[1]}, 32'h0);
            if (i > 0) begin
                chk("seq_dv", {30'h0, dv2}, 32'h1);
                chk("seq_data", {16'h0, data2}, {16'h0, rom_f(16'(i - 1))});
            end
            step();
        end
        av2 = '0;
        @(negedge clk);
        chk("seq_dv_last", {30'h0, dv2}, 32'h1);
        chk("seq_data_last", {16'h0, data2}, {16'h0, rom_f(16'h3)});
        step();
        do_reset();
        av2 = 2'b11;
        ad2 = {16'h20, 16'h10};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_grant", {30'h0, ar2}, (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) begin
                chk("alt_dv", {30'h0, dv2}, (i % 2 == 1) ? 32'h1 : 32'h2);
                chk("alt_data", {16'h0, data2}, {16'h0, rom_f((i % 2 == 1) ? 16'h10 : 16'h20)});
            end
            step();
        end
        do_reset();
        av2 = 2'b01;
        ad2 = {16'h33, 16'h5};
        dr2 = 2'b00;
        @(negedge clk);
        chk("bp_grant0", {30'h0, ar2}, 32'h1);
        step();
        av2 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_dv", {30'h0, dv2}, 32'h1);
            chk("bp_data", {16'h0, data2}, {16'h0, rom_f(16'h5)});
            chk("bp_ready", {30'h0, ar2}, 32'h0);
            step();
        end
        dr2 = 2'b01;
        @(negedge clk);
        chk("bp_release_grant", {30'h0, ar2}, 32'h2);
        chk("bp_release_addr", {16'h0, addr2}, 32'h33);
        step();
        av2 = '0;
        dr2 = 2'b11;
        @(negedge clk);
        chk("bp_dv1", {30'h0, dv2}, 32'h2);
        chk("bp_data1", {16'h0, data2}, {16'h0, rom_f(16'h33)});
        repeat (5) step();
        av2 = 2'b11;
        ad2 = {16'h22, 16'h11};
        @(negedge clk);
        chk("ptr_hold_grant", {30'h0, ar2}, 32'h1);
        step();
        av2 = '0;
        step();
        dr2 = 2'b00;
        av2 = 2'b10;
        ad2 = {16'h44, 16'h11};
        @(negedge clk);
        chk("ar_grant1", {30'h0, ar2}, 32'h2);
        step();
        av2 = 2'b11;
        @(negedge clk);
        chk("ar_dv1", {30'h0, dv2}, 32'h2);
        chk("ar_stalled", {30'h0, ar2}, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_async_dv", {30'h0, dv2}, 32'h0);
        chk("ar_async_ready", {30'h0, ar2}, 32'h0);
        chk("ar_async_en", {31'h0, en2}, 32'h0);
        step();
        rst = 1'b1;
        dr2 = 2'b11;
        @(negedge clk);
        chk("ar_after_grant0", {30'h0, ar2}, 32'h1);
        step();
        av2 = '0;
        dr4 = 4'hf;
        av4 = 4'b0010;
        ad4 = {16'h303, 16'h202, 16'h101, 16'h0};
        @(negedge clk);
        chk("n4_first", {28'h0, ar4}, 32'h2);
        step();
        av4 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("n4_sparse", {28'h0, ar4}, (i % 2 == 0) ? 32'h8 : 32'h2);
            step();
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (hs2[k] || !av2[k]) begin
                    av2[k] = 1'($urandom_range(0, 1));
                    ad2[k*16 +: 16] = 16'($urandom_range(0, 255));
                end
                dr2[k] = ($urandom_range(0, 3) != 0);
            end
            for (int k = 0; k < 4; k++) begin
                if (hs4[k] || !av4[k]) begin
                    av4[k] = 1'($urandom_range(0, 1));
                    ad4[k*16 +: 16] = 16'($urandom_range(0, 255));
                end
                dr4[k] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 149) != 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
